// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Holds state encoding, opcodes, mux select encodings and ALU operation codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: maps ALUOp, Funct3, Funct7b5 and Op[5] to ALUControl.
// Ports: alu_op, funct3, funct7b5, op5 in; alu_control out. Purely combinational.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) with funct7b5 selects sub.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main Moore control FSM of the multicycle RV32I core.
// Ports: clk, reset (sync, active-high), Op/Funct3/Funct7b5/Zero in;
// PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
// ImmSrc, ALUControl, Illegal out. CTRL_BNE_EN macro adds bne branch support.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned HALT_ON_ILLEGAL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       branch_cond;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        alu_op      = ALUOP_ADD;
        branch      = 1'b0;
        pc_update   = 1'b0;
        AdrSrc      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        Illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write_s = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                pc_update  = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Precompute branch target from OldPC + imm.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (Op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECUTER;
                    OP_ITYPE:          next_state = S_EXECUTEI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    default: begin
                        Illegal    = 1'b1;
                        next_state = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                next_state = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_s = 1'b1;
                next_state  = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
                next_state  = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RD1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                next_state  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            S_HALT: begin
                Illegal    = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_FETCH;
        endcase
    end

`ifdef CTRL_BNE_EN
    always_comb begin
        case (Funct3)
            3'b000:  branch_cond = Zero;
            3'b001:  branch_cond = ~Zero;
            default: branch_cond = 1'b0;
        endcase
    end
`else
    assign branch_cond = Zero & (Funct3 == 3'b000);
`endif

    // No architectural write may happen in a cycle where reset is high.
    assign PCWrite  = ~reset & (pc_update | (branch & branch_cond));
    assign IRWrite  = ~reset & ir_write_s;
    assign MemWrite = ~reset & mem_write_s;
    assign RegWrite = ~reset & reg_write_s;
    assign ImmSrc   = imm_src(Op);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (Funct3),
        .funct7b5    (Funct7b5),
        .op5         (Op[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM of the multicycle RV32I core. It sits directly upstream of the register file, the ALU, the PC, the instruction register and the unified memory. From the latched instruction fields it sequences each instruction through its fetch, decode, execute, memory and writeback steps. It drives every write enable and mux select, including `RegWrite`, which gates the register-file write port.

## Interface
Parameters:
- `HALT_ON_ILLEGAL`, default 0. 0: an unknown opcode is skipped (return to FETCH). 1: an unknown opcode enters HALT until reset.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `Op` in 7: instruction[6:0] from the instruction register.
- `Funct3` in 3: instruction[14:12].
- `Funct7b5` in 1: instruction[30].
- `Zero` in 1: ALU result == 0.
- `PCWrite` out 1: PC load enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction/OldPC register load.
- `RegWrite` out 1: register-file write enable.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU operand A. 00 = PC, 01 = OldPC, 10 = RD1 register.
- `ALUSrcB` out 2: ALU operand B. 00 = RD2 register, 01 = ImmExt, 10 = constant 4.
- `ImmSrc` out 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `Illegal` out 1: unknown opcode flag.

## Operation
- Moore FSM. Internal `ALUOp` (2b), `Branch` and `PCUpdate` are functions of state only.
- Outputs not listed for a state are 0/00.
- `PCWrite = PCUpdate | (Branch & branch_cond)`.
- States and their outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute). Next, by `Op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other → FETCH (or HALT when `HALT_ON_ILLEGAL`=1); `Illegal`=1 in this cycle.
  - MEMADR: ALUSrcA=10, ALUSrcB=01. Next: MEMREAD if `Op`=0000011, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1. Next: ALUWB.
  - HALT: all enables 0, `Illegal`=1. Next: HALT.
- `ImmSrc` is combinational from `Op` in every state:
  - 0100011 → 01; 1100011 → 10; 1101111 → 11; otherwise 00.
- ALU decoder:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10, by `Funct3`:
    - 000 → sub if `Op[5]`&`Funct7b5`, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - other → add

## Timing
- State register updates on `posedge clk`. All outputs are combinational from state and inputs; there is no output register.
- `reset` high at an edge → state = FETCH.
- While `reset` is high, `PCWrite`, `IRWrite`, `MemWrite` and `RegWrite` are forced to 0 combinationally. This also applies when reset lands mid-instruction (e.g. during MEMWRITE): no write occurs in any cycle where `reset` is high.
- First cycle with `reset` low is a FETCH with all FETCH enables active.
- Latency in cycles, FETCH to the next FETCH:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - branch: 3
  - skipped illegal opcode: 2
- `RegWrite` is high for exactly one cycle per lw / R / I / jal instruction.
- `Zero` is sampled only in BRANCH.

## Configuration
- `CTRL_BNE_EN` defined: `branch_cond = (Funct3==001) ? ~Zero : Zero` for `Funct3` ∈ {000, 001}. Any other `Funct3` gives `branch_cond`=0.
- `CTRL_BNE_EN` undefined: `branch_cond = Zero & (Funct3==000)`. bne still takes 3 cycles but never writes PC in BRANCH.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - state enum
  - opcode localparams
  - `ALUControl` encodings
  - `ResultSrc`, `ALUSrcA`, `ALUSrcB` and `ImmSrc` encodings
- Sub-module `alu_decoder`: combinational ALUOp/Funct3/Funct7b5/Op[5] → `ALUControl`. Instantiated once.

## Test plan
- Hold `reset` 2 cycles → all four enables 0. Release → cycle 1: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- R-type (Op=0110011, Funct3=000, Funct7b5=0) → states FETCH, DECODE, EXECUTER (ALUControl=000), ALUWB (RegWrite=1), then FETCH. Repeat with Funct7b5=1 → ALUControl=001.
- lw (0000011) → 5 cycles; AdrSrc=1 in cycle 4; RegWrite=1 with ResultSrc=01 only in cycle 5. sw (0100011) → 4 cycles; ImmSrc=01; MemWrite=1 only in cycle 4.
- beq (1100011, Funct3=000):
  - Zero=1 → PCWrite=1 in cycle 3.
  - Zero=0 → PCWrite=0.
  - bne (Funct3=001) with Zero=0 → PCWrite=1 only if `CTRL_BNE_EN` is defined.
- jal (1101111) → ImmSrc=11. JAL cycle: PCWrite=1, ALUSrcA=01, ALUSrcB=10. ALUWB cycle: RegWrite=1.
- Op=1111111:
  - `HALT_ON_ILLEGAL`=0 → Illegal=1 in DECODE, then FETCH.
  - `HALT_ON_ILLEGAL`=1 → HALT with enables 0 for 10+ cycles, until a `reset` pulse returns the FSM to FETCH.
  - `reset` asserted during MEMWRITE → MemWrite=0 in that same cycle.
